// File: rtl/ysyx_22041412_intr_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22041412_intr_ctrl
//
// Machine-mode interrupt controller. It combines the pending machine
// interrupt lines with their mie enables and the global MIE bit. It picks the
// highest-priority source (external > software > timer) and asks the pipeline
// for an instruction-boundary slot. Once the pipeline accepts, the controller
// sequences trap entry:
//   SAVE : one-cycle CSR write strobe (mepc/mcause/mstatus update)
//   JUMP : one-cycle fetch redirect to the mtvec-derived handler address
//
// Ports
//   clk            system clock, all state on the rising edge
//   rst            synchronous active-high reset
//   irq_pend[2:0]  pending levels  {MEIP, MSIP, MTIP}
//   irq_en[2:0]    mie enables     {MEIE, MSIE, MTIE}
//   mstatus_mie    global machine interrupt enable
//   mtvec          trap vector CSR, [1:0] = mode
//   commit_pc      PC of the next instruction to commit (valid with pipe_ack)
//   pipe_ack       pipeline is at a boundary and takes the interrupt
//   intr_req       interrupt request to the pipeline
//   intr_busy      trap entry in progress, pipeline must not commit
//   trap_we        CSR write strobe for trap entry
//   trap_mepc      latched commit_pc
//   trap_mcause    {1, 0..., code[3:0]}
//   redirect_valid one-cycle fetch redirect
//   redirect_pc    trap handler address (meaningful with redirect_valid)
// ---------------------------------------------------------------------------
module ysyx_22041412_intr_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      irq_pend,
    input  logic [2:0]      irq_en,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            pipe_ack,
    output logic            intr_req,
    output logic            intr_busy,
    output logic            trap_we,
    output logic [XLEN-1:0] trap_mepc,
    output logic [XLEN-1:0] trap_mcause,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SAVE = 2'd2;
    localparam logic [1:0] S_JUMP = 2'd3;

    localparam logic [3:0] CODE_MEI = 4'd11;
    localparam logic [3:0] CODE_MSI = 4'd3;
    localparam logic [3:0] CODE_MTI = 4'd7;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] w_mepc_next;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] w_mcause_next;

    logic [2:0]      w_eligible;
    logic            w_any;
    logic [3:0]      w_code;
    logic            w_take;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_vec_off;
    logic [XLEN-1:0] w_target;

    assign w_eligible = irq_pend & irq_en & {3{mstatus_mie}};
    assign w_any      = |w_eligible;

    // Later assignments override earlier ones, so the last test is the
    // highest priority source.
    always_comb begin
        w_code = 4'd0;
        if (w_eligible[0]) w_code = CODE_MTI;
        if (w_eligible[1]) w_code = CODE_MSI;
        if (w_eligible[2]) w_code = CODE_MEI;
    end

    // Acceptance needs a still-eligible source: a request withdrawn in the
    // same cycle as the ack must not start trap entry.
    assign w_take = (r_state == S_REQ) && pipe_ack && w_any;

    always_comb begin
        w_state_next  = r_state;
        w_mepc_next   = r_mepc;
        w_mcause_next = r_mcause;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_next = S_REQ;
            end
            S_REQ: begin
                if (!w_any) begin
                    w_state_next = S_IDLE;
                end else if (w_take) begin
                    w_state_next  = S_SAVE;
                    w_mepc_next   = commit_pc;
                    w_mcause_next = {1'b1, {(XLEN-5){1'b0}}, w_code};
                end
            end
            S_SAVE:  w_state_next = S_JUMP;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mepc   <= '0;
            r_mcause <= '0;
        end else begin
            r_state  <= w_state_next;
            r_mepc   <= w_mepc_next;
            r_mcause <= w_mcause_next;
        end
    end

    // Handler address: mode 1 is vectored (base + 4*code); every other mode,
    // including the reserved ones, jumps straight to the base. The addition
    // wraps naturally at XLEN bits.
    assign w_base    = {mtvec[XLEN-1:2], 2'b00};
    assign w_vec_off = {{(XLEN-6){1'b0}}, r_mcause[3:0], 2'b00};
    assign w_target  = (mtvec[1:0] == 2'b01) ? (w_base + w_vec_off) : w_base;

    assign intr_req       = (r_state == S_REQ) && w_any;
    assign intr_busy      = (r_state == S_SAVE) || (r_state == S_JUMP);
    assign trap_we        = (r_state == S_SAVE);
    assign redirect_valid = (r_state == S_JUMP);
    assign trap_mepc      = r_mepc;
    assign trap_mcause    = r_mcause;
    // Forced to zero outside JUMP so the output is clean after reset.
    assign redirect_pc    = (r_state == S_JUMP) ? w_target : '0;

endmodule

// File: tb/tb_ysyx_22041412_intr_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_22041412_intr_ctrl: table of complete trap entries,
// hand-written multi-cycle corner cases, then randomized traffic compared
// against a cycle-level behavioural model.
// ---------------------------------------------------------------------------
module tb_ysyx_22041412_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_pend;
    logic [2:0]  irq_en;
    logic        mstatus_mie;
    logic [63:0] mtvec;
    logic [63:0] commit_pc;
    logic        pipe_ack;
    logic        intr_req;
    logic        intr_busy;
    logic        trap_we;
    logic [63:0] trap_mepc;
    logic [63:0] trap_mcause;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_22041412_intr_ctrl #(.XLEN(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_pend       (irq_pend),
        .irq_en         (irq_en),
        .mstatus_mie    (mstatus_mie),
        .mtvec          (mtvec),
        .commit_pc      (commit_pc),
        .pipe_ack       (pipe_ack),
        .intr_req       (intr_req),
        .intr_busy      (intr_busy),
        .trap_we        (trap_we),
        .trap_mepc      (trap_mepc),
        .trap_mcause    (trap_mcause),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [2:0]  pend;
        logic [2:0]  en;
        logic [63:0] tvec;
        logic [63:0] pc;
        logic [63:0] exp_mcause;
        logic [63:0] exp_rpc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%016h required=0x%016h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic [2:0] p, input logic [2:0] e, input logic m,
                         input logic [63:0] tv, input logic [63:0] pc, input logic a);
        irq_pend    = p;
        irq_en      = e;
        mstatus_mie = m;
        mtvec       = tv;
        commit_pc   = pc;
        pipe_ack    = a;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'b000, 3'b000, 1'b0, 64'h0, 64'h0, 1'b0);
        cyc();
        rst = 1'b0;
    endtask

    // Reference: highest-priority code among eligible sources.
    function automatic logic [3:0] ref_code(input logic [2:0] elig);
        if (elig[2]) return 4'd11;
        if (elig[1]) return 4'd3;
        if (elig[0]) return 4'd7;
        return 4'd0;
    endfunction

    function automatic logic [63:0] ref_target(input logic [63:0] tv, input logic [3:0] code);
        logic [63:0] base;
        base = tv & ~64'h3;
        if (tv[1:0] == 2'b01) return base + 64'(code) * 64'd4;
        return base;
    endfunction

    // Behavioural model state for the random phase.
    bit          m_req;
    int          m_left;      // trap-entry cycles still to come: 2 = save, 1 = jump
    logic [63:0] m_mepc;
    logic [63:0] m_mcause;

    initial begin
        vecs[0] = '{3'b001, 3'b001, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0100,
                    64'h8000_0000_0000_0007, 64'h0000_0000_8000_0000};
        vecs[1] = '{3'b111, 3'b111, 64'h0000_0000_8000_0001, 64'h0000_0000_8000_0200,
                    64'h8000_0000_0000_000B, 64'h0000_0000_8000_002C};
        vecs[2] = '{3'b111, 3'b011, 64'h0000_0000_8000_0001, 64'h0000_0000_8000_0300,
                    64'h8000_0000_0000_0003, 64'h0000_0000_8000_000C};
        vecs[3] = '{3'b001, 3'b111, 64'h0000_0000_8000_0001, 64'h1234_5678_9ABC_DEF0,
                    64'h8000_0000_0000_0007, 64'h0000_0000_8000_001C};
        vecs[4] = '{3'b110, 3'b110, 64'h0000_0000_4000_0002, 64'h0000_0000_0000_0004,
                    64'h8000_0000_0000_000B, 64'h0000_0000_4000_0000};
        vecs[5] = '{3'b010, 3'b111, 64'h0000_0000_4000_0013, 64'hFFFF_FFFF_FFFF_FFF8,
                    64'h8000_0000_0000_0003, 64'h0000_0000_4000_0010};
        vecs[6] = '{3'b100, 3'b100, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_0000_1000,
                    64'h8000_0000_0000_000B, 64'h0000_0000_0000_0028};

        // ---------------- reset state ----------------
        do_reset();
        settle();
        chk("reset_intr_req",  intr_req,       0);
        chk("reset_busy",      intr_busy,      0);
        chk("reset_trap_we",   trap_we,        0);
        chk("reset_redirect",  redirect_valid, 0);
        chk("reset_mepc",      trap_mepc,      0);
        chk("reset_mcause",    trap_mcause,    0);
        chk("reset_rpc",       redirect_pc,    0);

        // ---------------- table-driven trap entries ----------------
        for (int v = 0; v < 7; v++) begin
            do_reset();
            drive(vecs[v].pend, vecs[v].en, 1'b1, vecs[v].tvec, vecs[v].pc, 1'b0);
            settle();
            chk("vec_req_not_yet", intr_req, 0);
            cyc();                       // REQ, one cycle after eligible rose
            pipe_ack = 1'b1;
            settle();
            chk("vec_req", intr_req, 1);
            cyc();                       // SAVE
            pipe_ack = 1'b0;
            settle();
            chk("vec_trap_we", trap_we,     1);
            chk("vec_busy",    intr_busy,   1);
            chk("vec_mepc",    trap_mepc,   vecs[v].pc);
            chk("vec_mcause",  trap_mcause, vecs[v].exp_mcause);
            cyc();                       // JUMP
            settle();
            chk("vec_redirect",      redirect_valid, 1);
            chk("vec_rpc",           redirect_pc,    vecs[v].exp_rpc);
            chk("vec_we_one_cycle",  trap_we,        0);
            cyc();                       // IDLE
            settle();
            chk("vec_redirect_end",  redirect_valid, 0);
            chk("vec_busy_end",      intr_busy,      0);
            $display("vector %0d: mcause=0x%016h redirect_pc=0x%016h", v, vecs[v].exp_mcause, vecs[v].exp_rpc);
        end

        // ---------------- masking ----------------
        do_reset();
        drive(3'b111, 3'b111, 1'b0, 64'h0, 64'h0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            cyc();
            settle();
            chk("mask_mie0", intr_req, 0);
        end
        drive(3'b111, 3'b000, 1'b1, 64'h0, 64'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc();
            settle();
            chk("mask_en0", intr_req, 0);
        end
        drive(3'b111, 3'b111, 1'b0, 64'h0, 64'h0, 1'b0);
        cyc();
        mstatus_mie = 1'b1;
        settle();
        chk("mask_unmask_same_cycle", intr_req, 0);
        cyc();
        settle();
        chk("mask_unmask_next_cycle", intr_req, 1);
        $display("masking sequence done");

        // ---------------- withdrawal ----------------
        do_reset();
        drive(3'b001, 3'b001, 1'b1, 64'h8000_0000, 64'h100, 1'b0);
        cyc();
        settle();
        chk("wd_req", intr_req, 1);
        cyc();
        irq_pend = 3'b000;
        settle();
        chk("wd_drop_same_cycle", intr_req, 0);
        cyc();                           // back in IDLE
        irq_pend = 3'b001;
        pipe_ack = 1'b1;
        settle();
        chk("wd_idle_no_req", intr_req, 0);
        cyc();
        pipe_ack = 1'b0;
        settle();
        chk("wd_no_trap_we", trap_we,   0);
        chk("wd_no_busy",    intr_busy, 0);
        chk("wd_rerequest",  intr_req,  1);
        $display("withdrawal sequence done");

        // ---------------- cause change in the ack cycle ----------------
        do_reset();
        drive(3'b001, 3'b111, 1'b1, 64'h8000_0001, 64'hABC0, 1'b0);
        cyc();
        settle();
        chk("cc_req", intr_req, 1);
        cyc();
        irq_pend = 3'b011;
        pipe_ack = 1'b1;
        settle();
        cyc();
        pipe_ack = 1'b0;
        settle();
        chk("cc_mcause", trap_mcause, 64'h8000_0000_0000_0003);
        chk("cc_mepc",   trap_mepc,   64'hABC0);
        cyc();
        settle();
        chk("cc_rpc", redirect_pc, 64'h8000_000C);
        $display("cause change sequence done");

        // ---------------- ack pulses outside REQ / inputs frozen ----------------
        do_reset();
        drive(3'b000, 3'b001, 1'b1, 64'h1000_0001, 64'h2000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            settle();
            chk("ack_idle_no_we",   trap_we,   0);
            chk("ack_idle_no_busy", intr_busy, 0);
        end
        irq_pend = 3'b001;               // eligible rises, ack held high
        cyc();                           // REQ with ack: acceptance cycle
        settle();
        chk("ack_req", intr_req, 1);
        cyc();                           // SAVE: change everything
        irq_pend  = 3'b100;
        irq_en    = 3'b100;
        commit_pc = 64'h9999;
        settle();
        chk("ack_save_we",    trap_we,     1);
        chk("ack_save_mepc",  trap_mepc,   64'h2000);
        cyc();                           // JUMP
        irq_pend = 3'b001;
        irq_en   = 3'b001;
        settle();
        chk("ack_jump_we",     trap_we,     0);
        chk("ack_jump_mcause", trap_mcause, 64'h8000_0000_0000_0007);
        chk("ack_jump_mepc",   trap_mepc,   64'h2000);
        chk("ack_jump_rpc",    redirect_pc, 64'h1000_001C);
        cyc();                           // IDLE (A+3)
        settle();
        chk("ack_a3_req",   intr_req,       0);
        chk("ack_a3_we",    trap_we,        0);
        chk("ack_a3_redir", redirect_valid, 0);
        chk("ack_a3_busy",  intr_busy,      0);
        pipe_ack = 1'b0;
        cyc();                           // A+4
        settle();
        chk("ack_a4_req", intr_req, 1);
        $display("ack-outside-REQ sequence done");

        // ---------------- reset in SAVE ----------------
        do_reset();
        drive(3'b100, 3'b100, 1'b1, 64'h8000_0001, 64'h4444, 1'b0);
        cyc();
        pipe_ack = 1'b1;
        settle();
        cyc();                           // SAVE
        pipe_ack = 1'b0;
        rst = 1'b1;
        settle();
        chk("rs_save_we", trap_we, 1);
        cyc();
        rst = 1'b0;
        settle();
        chk("rs_req",    intr_req,       0);
        chk("rs_busy",   intr_busy,      0);
        chk("rs_we",     trap_we,        0);
        chk("rs_redir",  redirect_valid, 0);
        chk("rs_mepc",   trap_mepc,      0);
        chk("rs_mcause", trap_mcause,    0);
        chk("rs_rpc",    redirect_pc,    0);
        cyc();
        settle();
        chk("rs_no_redirect_later", redirect_valid, 0);
        chk("rs_no_we_later",       trap_we,        0);
        $display("reset-in-SAVE sequence done");

        // ---------------- randomized traffic vs model ----------------
        do_reset();
        m_req    = 1'b0;
        m_left   = 0;
        m_mepc   = '0;
        m_mcause = '0;
        for (int i = 0; i < 4000; i++) begin
            logic [2:0]  elig;
            logic [63:0] tv;
            logic [63:0] pc;
            cyc();
            tv = {$urandom, $urandom};
            pc = {$urandom, $urandom};
            rst = ($urandom_range(0, 99) == 0);
            drive(3'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 8) ? 3'b111 : 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 8),
                  tv, pc,
                  ($urandom_range(0, 2) == 0));
            settle();
            elig = irq_pend & irq_en & {3{mstatus_mie}};

            chk("rand_intr_req", intr_req,       (m_req && elig != 0));
            chk("rand_busy",     intr_busy,      (m_left > 0));
            chk("rand_trap_we",  trap_we,        (m_left == 2));
            chk("rand_redirect", redirect_valid, (m_left == 1));
            chk("rand_mepc",     trap_mepc,      m_mepc);
            chk("rand_mcause",   trap_mcause,    m_mcause);
            if (m_left == 1)
                chk("rand_rpc", redirect_pc, ref_target(mtvec, m_mcause[3:0]));

            // Model advance at the coming clock edge.
            if (rst) begin
                m_req    = 1'b0;
                m_left   = 0;
                m_mepc   = '0;
                m_mcause = '0;
            end else if (m_left > 0) begin
                m_left--;
                m_req = 1'b0;
            end else if (m_req) begin
                if (elig == 0) begin
                    m_req = 1'b0;
                end else if (pipe_ack) begin
                    m_req    = 1'b0;
                    m_left   = 2;
                    m_mepc   = commit_pc;
                    m_mcause = 64'h8000_0000_0000_0000 | 64'(ref_code(elig));
                end
            end else begin
                m_req = (elig != 0);
            end
        end
        rst = 1'b0;
        $display("random phase done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22041412_intr_ctrl.md
# ysyx_22041412_intr_ctrl

Machine-mode interrupt controller that sits between the CLINT/external interrupt sources, the CSR file and the pipeline commit stage. It arbitrates pending-and-enabled interrupts by RISC-V priority and requests an instruction-boundary slot from the pipeline. Once granted, it sequences trap entry: it writes mepc/mcause, triggers the mstatus update, and redirects fetch to the mtvec target.

## Interface
- XLEN, 64, data/address width of mepc, mcause, mtvec, PCs
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- irq_pend  in  3  level pending: [2]=external (MEIP), [1]=software (MSIP), [0]=timer (MTIP, from mtime compare)
- irq_en  in  3  mie enables, same bit order (MEIE, MSIE, MTIE)
- mstatus_mie  in  1  global machine interrupt enable
- mtvec  in  XLEN  trap vector CSR; [1:0] is the mode
- commit_pc  in  XLEN  PC of the next instruction to commit; valid with pipe_ack
- pipe_ack  in  1  pipeline is at an instruction boundary and accepts the interrupt
- intr_req  out  1  interrupt request to the pipeline
- intr_busy  out  1  high in SAVE and JUMP; the pipeline must not commit
- trap_we  out  1  one-cycle CSR write strobe: mepc<=trap_mepc, mcause<=trap_mcause, MPIE<=MIE, MIE<=0, MPP<=M
- trap_mepc  out  XLEN  latched commit_pc
- trap_mcause  out  XLEN  {1'b1, (XLEN-5)'b0, code[3:0]}
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  XLEN  trap handler address

## Operation
- eligible = irq_pend & irq_en & {3{mstatus_mie}}.
- Priority is external > software > timer. The codes are MEI=11, MSI=3, MTI=7.
- FSM states: IDLE, REQ, SAVE, JUMP.
  - IDLE: if |eligible, go to REQ. Otherwise stay.
  - REQ: intr_req = |eligible (combinational from state and inputs).
    - If eligible==0, return to IDLE. The request is withdrawn the same cycle it is seen low.
    - If pipe_ack && |eligible, latch the highest-priority code and commit_pc, then go to SAVE.
    - The code is re-arbitrated every REQ cycle. The value latched is the one present in the ack cycle.
  - SAVE: trap_we=1, intr_busy=1. Go to JUMP.
  - JUMP: redirect_valid=1, intr_busy=1. Go to IDLE.
- redirect_pc is computed from the mtvec value sampled in JUMP:
  - mtvec[1:0]==1 (vectored): {mtvec[XLEN-1:2],2'b00} + 4*code.
  - mtvec[1:0]==0, 2 or 3: {mtvec[XLEN-1:2],2'b00}. Reserved modes are treated as direct.
  - Arithmetic wraps modulo 2^XLEN.
- pipe_ack outside REQ is ignored.
- Pending or enable changes during SAVE/JUMP are ignored. The latched code and PC stay fixed.
- The CSR file clears MIE at the end of SAVE. IDLE after JUMP therefore sees eligible==0 until mret restores MIE, so no back-to-back re-entry occurs.

## Timing
- Reset (synchronous) sets state=IDLE and the latched code/PC to 0.
  - Outputs after the reset edge: intr_req=0, intr_busy=0, trap_we=0, redirect_valid=0, trap_mepc=0, trap_mcause=0, redirect_pc=0.
  - rst asserted in REQ/SAVE/JUMP aborts the sequence. No trap_we or redirect_valid follows reset.
- Detect latency: eligible rises in cycle N, intr_req is high in cycle N+1.
- Ack in cycle A: trap_we in A+1, redirect_valid in A+2, IDLE in A+3. The earliest next intr_req is A+4.
- trap_we and redirect_valid are each exactly one cycle wide and mutually exclusive.
- trap_mepc and trap_mcause are registered and stable from A+1 until the next ack.
- redirect_pc is valid whenever redirect_valid=1. Its value is don't-care otherwise.

## Test plan
- Timer only: irq_pend=3'b001, irq_en=3'b001, mstatus_mie=1, mtvec=0x8000_0000, ack with commit_pc=0x8000_0100.
  - Required: trap_we with mepc=0x8000_0100 and mcause=0x8000_0000_0000_0007.
  - Required: redirect_pc=0x8000_0000.
- Simultaneous sources: irq_pend=3'b111, irq_en=3'b111, vectored mtvec=0x8000_0001.
  - Required: mcause code 11, redirect_pc=0x8000_002C.
  - With irq_en=3'b011: code 3, redirect_pc=0x8000_000C.
- Masking: irq_pend=3'b111 with mstatus_mie=0, or with irq_en=0.
  - Required: intr_req stays 0 for 100 cycles. Setting mstatus_mie=1 raises intr_req exactly one cycle later.
- Withdrawal: enter REQ with timer pending, then drop irq_pend[0] before ack.
  - Required: intr_req falls the same cycle and the FSM returns to IDLE.
  - Required: an ack in the following cycle produces no trap_we.
- Cause change in REQ: timer pending, software rises in the ack cycle.
  - Required: mcause code 3.
  - Required: pipe_ack pulses in IDLE/SAVE/JUMP have no effect.
- Reset mid-sequence: assert rst in the SAVE cycle.
  - Required: all outputs are 0 after the edge, no redirect_valid, and the FSM is in IDLE.
